vin_burst_writer_mc: RTL and testbench

Parametrised successor to the per-channel video-in frame buffer write controllers. It runs entirely in mem_clk and drains an external 16-in/MEM_DATA_BITS-out line FIFO into DDR as bursts. Over the previous generation it adds:
- configurable burst, address and line geometry;
- a short tail burst, so widths that are not a multiple of BURST_LEN do not stall;
- config shadowing at frame start;
- safe deferral of a frame restart that arrives mid-burst;
- height-limited frames;
- BUF_NUM-deep frame-buffer rotation with a completed-frame index for the reader.

---
 rtl/vin_burst_writer_mc_if.sv | 27 ++
 rtl/vin_burst_writer_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_vin_burst_writer_mc.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vin_burst_writer_mc_if.sv
// Burst write channel between the frame-buffer writer and the DDR memory controller.
interface vin_burst_writer_mc_if #(
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned LEN_BITS  = 10
);
  logic                 wr_burst_req;
  logic [LEN_BITS-1:0]  wr_burst_len;
  logic [ADDR_BITS-1:0] wr_burst_addr;
  logic                 wr_burst_data_req;
  logic                 burst_finish;

  modport master (
    output wr_burst_req,
    output wr_burst_len,
    output wr_burst_addr,
    input  wr_burst_data_req,
    input  burst_finish
  );

  modport slave (
    input  wr_burst_req,
    input  wr_burst_len,
    input  wr_burst_addr,
    output wr_burst_data_req,
    output burst_finish
  );
endinterface

// File: rtl/vin_burst_writer_mc.sv
// Video-in frame-buffer write controller: drains the line FIFO into DDR as bursts,
// with config shadowing, deferred mid-burst restarts and rotating frame buffers.
module vin_burst_writer_mc #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned BURST_LEN     = 128,
  parameter int unsigned LEN_BITS      = 10,
  parameter int unsigned USEDW_BITS    = 12,
  parameter int unsigned LINE_SHIFT    = 11,
  parameter int unsigned FRAME_SHIFT   = 22,
  parameter int unsigned BUF_NUM       = 3,
  parameter int unsigned ACLR_CYCLES   = 4
) (
  input  logic                  mem_clk,
  input  logic                  rst_n,
  input  logic                  vin_vs,
  input  logic [USEDW_BITS-1:0] fifo_rdusedw,
  output logic                  fifo_aclr,
  input  logic [LINE_SHIFT-1:0] cfg_base_x,
  input  logic [11:0]           cfg_base_y,
  input  logic [11:0]           cfg_width,
  input  logic [11:0]           cfg_height,
  vin_burst_writer_mc_if.master wr_bus,
  output logic [1:0]            wr_buf_idx,
  output logic [1:0]            done_buf_idx,
  output logic                  frame_done
);

  localparam int unsigned         AclrW    = (ACLR_CYCLES > 1) ? $clog2(ACLR_CYCLES) : 1;
  localparam logic [AclrW-1:0]    AclrLoad = AclrW'(ACLR_CYCLES - 1);
  localparam logic [11:0]         BurstLen = 12'(BURST_LEN);
  localparam logic [1:0]          LastBuf  = 2'(BUF_NUM - 1);

  if (BUF_NUM < 2 || BUF_NUM > 4 || MEM_DATA_BITS == 0 || ACLR_CYCLES == 0 ||
      BURST_LEN >= (1 << LEN_BITS)) begin : g_param_check
    $error("vin_burst_writer_mc: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    StIdle, StLineStart, StWait, StReq, StLineEnd, StHold, StClear
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            vs_sync_q, vs_sync_d;
  logic                  vs_prev_q, vs_prev_d;
  logic                  vs_pend_q, vs_pend_d;
  logic                  aclr_q, aclr_d;
  logic [AclrW-1:0]      aclr_cnt_q, aclr_cnt_d;
  logic [LINE_SHIFT-1:0] base_x_q, base_x_d;
  logic [11:0]           base_y_q, base_y_d;
  logic [11:0]           width_q, width_d;
  logic [11:0]           height_q, height_d;
  logic [11:0]           line_q, line_d;
  logic [11:0]           remain_q, remain_d;
  logic [11:0]           col_q, col_d;
  logic                  req_q, req_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [1:0]            buf_q, buf_d;
  logic [1:0]            done_buf_q, done_buf_d;
  logic                  frame_done_q, frame_done_d;
  logic                  cmpl_q, cmpl_d;

  logic                  vs_rise;
  logic                  restart;
  logic [11:0]           need;

  always_comb begin
    state_d      = state_q;
    vs_sync_d    = {vs_sync_q[0], vin_vs};
    vs_prev_d    = vs_sync_q[1];
    aclr_d       = aclr_q;
    aclr_cnt_d   = aclr_cnt_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    width_d      = width_q;
    height_d     = height_q;
    line_d       = line_q;
    remain_d     = remain_q;
    col_d        = col_q;
    req_d        = req_q;
    len_d        = len_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    done_buf_d   = done_buf_q;
    frame_done_d = 1'b0;
    cmpl_d       = cmpl_q;

    vs_rise = vs_sync_q[1] & ~vs_prev_q;
    need    = (remain_q < BurstLen) ? remain_q : BurstLen;

    // A restart pending during a burst waits for burst_finish; during the clear pulse it waits.
    if (state_q == StReq) begin
      restart = vs_pend_q & wr_bus.burst_finish;
    end else begin
      restart = vs_pend_q & (state_q != StClear);
    end

    if (restart) begin
      aclr_d     = 1'b1;
      aclr_cnt_d = AclrLoad;
      base_x_d   = cfg_base_x;
      base_y_d   = cfg_base_y;
      width_d    = cfg_width;
      height_d   = cfg_height;
      line_d     = '0;
      req_d      = 1'b0;
      // An incomplete frame's buffer is reused so the reader never sees a torn frame.
      if (cmpl_q) begin
        buf_d = (buf_q == LastBuf) ? 2'd0 : buf_q + 2'd1;
      end
      cmpl_d  = 1'b0;
      state_d = StClear;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (width_q != '0) state_d = StLineStart;
        end
        StLineStart: begin
          remain_d = width_q;
          col_d    = '0;
          state_d  = StWait;
        end
        StWait: begin
          if (32'(fifo_rdusedw) >= 32'(need)) begin
            len_d   = LEN_BITS'(need);
            addr_d  = ADDR_BITS'(32'(buf_q) << FRAME_SHIFT)
                    + ADDR_BITS'((32'(base_y_q) + 32'(line_q)) << LINE_SHIFT)
                    + ADDR_BITS'(base_x_q) + ADDR_BITS'(col_q);
            req_d   = 1'b1;
            state_d = StReq;
          end
        end
        StReq: begin
          if (wr_bus.wr_burst_data_req || wr_bus.burst_finish) req_d = 1'b0;
          if (wr_bus.burst_finish) begin
            remain_d = remain_q - 12'(len_q);
            col_d    = col_q + 12'(len_q);
            state_d  = (remain_d == '0) ? StLineEnd : StWait;
          end
        end
        StLineEnd: begin
          line_d = line_q + 12'd1;
          if (line_d == height_q) begin
            frame_done_d = 1'b1;
            done_buf_d   = buf_q;
            cmpl_d       = 1'b1;
            state_d      = StHold;
          end else begin
            state_d = StLineStart;
          end
        end
        StHold: begin
          state_d = StHold;
        end
        StClear: begin
          if (aclr_cnt_q == '0) begin
            aclr_d  = 1'b0;
            state_d = StIdle;
          end else begin
            aclr_cnt_d = aclr_cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    vs_pend_d = (vs_pend_q | vs_rise) & ~restart;
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vs_sync_q    <= '0;
      vs_prev_q    <= 1'b0;
      vs_pend_q    <= 1'b0;
      aclr_q       <= 1'b0;
      aclr_cnt_q   <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      line_q       <= '0;
      remain_q     <= '0;
      col_q        <= '0;
      req_q        <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      buf_q        <= '0;
      done_buf_q   <= '0;
      frame_done_q <= 1'b0;
      cmpl_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_sync_q    <= vs_sync_d;
      vs_prev_q    <= vs_prev_d;
      vs_pend_q    <= vs_pend_d;
      aclr_q       <= aclr_d;
      aclr_cnt_q   <= aclr_cnt_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      width_q      <= width_d;
      height_q     <= height_d;
      line_q       <= line_d;
      remain_q     <= remain_d;
      col_q        <= col_d;
      req_q        <= req_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      done_buf_q   <= done_buf_d;
      frame_done_q <= frame_done_d;
      cmpl_q       <= cmpl_d;
    end
  end

  assign fifo_aclr            = aclr_q;
  assign wr_bus.wr_burst_req  = req_q;
  assign wr_bus.wr_burst_len  = len_q;
  assign wr_bus.wr_burst_addr = addr_q;
  assign wr_buf_idx           = buf_q;
  assign done_buf_idx         = done_buf_q;
  assign frame_done           = frame_done_q;

endmodule

// File: tb/tb_vin_burst_writer_mc.sv
// Scoreboard bench for vin_burst_writer_mc: directed frames, expectations queued at issue,
// independent monitors compare bursts, clear pulses and completed-frame indices.
module tb_vin_burst_writer_mc;

  localparam int unsigned AddrBits = 24;
  localparam int unsigned LenBits  = 10;
  localparam int          BufNum   = 3;

  typedef struct {
    int addr;
    int len;
    int buf_idx;
  } burst_t;

  burst_t exp_burst_q[$];
  int     exp_done_q[$];
  int     exp_aclr_q[$];

  int checks   = 0;
  int failures = 0;

  logic        mem_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        vin_vs  = 1'b0;
  logic [11:0] fifo_rdusedw;
  logic        fifo_aclr;
  logic [10:0] cfg_base_x = '0;
  logic [11:0] cfg_base_y = '0;
  logic [11:0] cfg_width  = '0;
  logic [11:0] cfg_height = '0;
  logic [1:0]  wr_buf_idx;
  logic [1:0]  done_buf_idx;
  logic        frame_done;

  int level      = 0;
  int fill_total = 0;
  int fill_done  = 0;
  bit in_flight  = 1'b0;
  int exp_buf    = 0;
  bit exp_cmpl   = 1'b0;

  always #5 mem_clk = ~mem_clk;

  vin_burst_writer_mc_if #(.ADDR_BITS(AddrBits), .LEN_BITS(LenBits)) wr_bus ();

  vin_burst_writer_mc #(.BUF_NUM(BufNum)) dut (
    .mem_clk      (mem_clk),
    .rst_n        (rst_n),
    .vin_vs       (vin_vs),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_aclr    (fifo_aclr),
    .cfg_base_x   (cfg_base_x),
    .cfg_base_y   (cfg_base_y),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .wr_bus       (wr_bus),
    .wr_buf_idx   (wr_buf_idx),
    .done_buf_idx (done_buf_idx),
    .frame_done   (frame_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // Line FIFO model: one word written per cycle while a frame's words are pending.
  assign fifo_rdusedw = 12'(level);
  always @(posedge mem_clk) begin
    if (fifo_aclr) begin
      level     <= 0;
      fill_done <= fill_total;
    end else begin
      int nxt;
      nxt = level;
      if (fill_done < fill_total && level < 4095) begin
        nxt = nxt + 1;
        fill_done <= fill_done + 1;
      end
      if (wr_bus.wr_burst_data_req && nxt > 0) nxt = nxt - 1;
      level <= nxt;
    end
  end

  // Memory controller model: 2-cycle latency, one word per cycle, then burst_finish.
  initial begin
    int blen;
    wr_bus.wr_burst_data_req = 1'b0;
    wr_bus.burst_finish      = 1'b0;
    forever begin
      @(posedge mem_clk); #1;
      if (rst_n && wr_bus.wr_burst_req) begin
        blen = int'(wr_bus.wr_burst_len);
        repeat (2) @(posedge mem_clk);
        #1;
        wr_bus.wr_burst_data_req = 1'b1;
        repeat (blen) begin
          @(posedge mem_clk); #1;
        end
        wr_bus.wr_burst_data_req = 1'b0;
        wr_bus.burst_finish      = 1'b1;
        @(posedge mem_clk); #1;
        wr_bus.burst_finish      = 1'b0;
      end
    end
  end

  // Burst monitor.
  initial begin
    bit          req_prev;
    burst_t      e;
    logic [23:0] cap_addr;
    logic [9:0]  cap_len;
    logic [1:0]  cap_buf;
    req_prev = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!rst_n) begin
        in_flight = 1'b0;
        req_prev  = 1'b0;
      end else begin
        if (wr_bus.wr_burst_req && !req_prev) begin
          if (exp_burst_q.size() == 0) begin
            timeout("unexpected_burst");
            $display("  burst addr 0x%0h len %0d", wr_bus.wr_burst_addr, wr_bus.wr_burst_len);
          end else begin
            e = exp_burst_q.pop_front();
            check("burst_addr", 64'(wr_bus.wr_burst_addr), 64'(e.addr));
            check("burst_len", 64'(wr_bus.wr_burst_len), 64'(e.len));
            check("burst_buf_idx", 64'(wr_buf_idx), 64'(e.buf_idx));
            check("burst_fifo_level_ok", 64'(fifo_rdusedw >= 12'(wr_bus.wr_burst_len)), 64'd1);
          end
          cap_addr  = wr_bus.wr_burst_addr;
          cap_len   = wr_bus.wr_burst_len;
          cap_buf   = wr_buf_idx;
          in_flight = 1'b1;
        end
        if (wr_bus.burst_finish && in_flight) begin
          check("stable_addr", 64'(wr_bus.wr_burst_addr), 64'(cap_addr));
          check("stable_len", 64'(wr_bus.wr_burst_len), 64'(cap_len));
          check("stable_buf_idx", 64'(wr_buf_idx), 64'(cap_buf));
          in_flight = 1'b0;
        end
        req_prev = wr_bus.wr_burst_req;
      end
    end
  end

  // FIFO clear pulse monitor.
  initial begin
    int width;
    width = 0;
    forever begin
      @(negedge mem_clk);
      if (!rst_n) begin
        width = 0;
      end else if (fifo_aclr) begin
        if (width == 0) check("aclr_not_mid_burst", 64'(in_flight), 64'd0);
        width++;
      end else if (width != 0) begin
        if (exp_aclr_q.size() == 0) timeout("unexpected_aclr");
        else check("aclr_width", 64'(width), 64'(exp_aclr_q.pop_front()));
        width = 0;
      end
    end
  end

  // Completed-frame monitor.
  initial begin
    forever begin
      @(negedge mem_clk);
      if (rst_n && frame_done) begin
        if (exp_done_q.size() == 0) timeout("unexpected_frame_done");
        else check("done_buf_idx", 64'(done_buf_idx), 64'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic wait_aclr_pulse();
    int n;
    n = 0;
    while (!fifo_aclr && n < 1000) begin
      @(negedge mem_clk);
      n++;
    end
    if (!fifo_aclr) timeout("aclr_rise_timeout");
    n = 0;
    while (fifo_aclr && n < 50) begin
      @(negedge mem_clk);
      n++;
    end
    if (fifo_aclr) timeout("aclr_fall_timeout");
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!wr_bus.wr_burst_req && n < 2000) begin
      @(negedge mem_clk);
      n++;
    end
    if (!wr_bus.wr_burst_req) timeout("req_timeout");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_burst_q.size() != 0 || exp_done_q.size() != 0 || in_flight) && n < 5000) begin
      @(negedge mem_clk);
      n++;
    end
    if (n >= 5000) timeout("drain_timeout");
  endtask

  // Queue the expected bursts of a frame, pulse vsync, wait out the clear, then feed words.
  task automatic start_frame(input int w, input int h, input int bx, input int by,
                             input int fill, input int max_bursts, input bit complete);
    int n;
    int col;
    int len;
    cfg_width  = 12'(w);
    cfg_height = 12'(h);
    cfg_base_x = 11'(bx);
    cfg_base_y = 12'(by);
    if (exp_cmpl) exp_buf = (exp_buf + 1) % BufNum;
    exp_cmpl = complete;
    n = 0;
    for (int l = 0; l < h; l++) begin
      col = 0;
      while (col < w) begin
        len = (w - col < 128) ? (w - col) : 128;
        if (n < max_bursts) begin
          exp_burst_q.push_back('{((exp_buf << 22) + ((by + l) << 11) + bx + col) & 24'hFFFFFF,
                                  len, exp_buf});
        end
        n++;
        col += len;
      end
    end
    if (complete) exp_done_q.push_back(exp_buf);
    exp_aclr_q.push_back(4);
    @(negedge mem_clk);
    vin_vs = 1'b1;
    repeat (3) @(negedge mem_clk);
    vin_vs = 1'b0;
    wait_aclr_pulse();
    fill_total = fill_total + fill;
  endtask

  initial begin
    repeat (3) @(negedge mem_clk);
    check("rst_fifo_aclr", 64'(fifo_aclr), 64'd0);
    check("rst_req", 64'(wr_bus.wr_burst_req), 64'd0);
    check("rst_len", 64'(wr_bus.wr_burst_len), 64'd0);
    check("rst_addr", 64'(wr_bus.wr_burst_addr), 64'd0);
    check("rst_wr_buf_idx", 64'(wr_buf_idx), 64'd0);
    check("rst_done_buf_idx", 64'(done_buf_idx), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge mem_clk);

    // Disabled channel: restart happens, no bursts.
    start_frame(0, 2, 0, 0, 0, 0, 1'b0);
    repeat (40) @(negedge mem_clk);

    // 256x2 into buffer 0.
    start_frame(256, 2, 0, 0, 512, 99, 1'b1);
    wait_drain();

    // 300-wide line with a 44-word tail; rotates to buffer 1 at 0x400000.
    start_frame(300, 1, 0, 0, 300, 99, 1'b1);
    wait_drain();

    // Height 1 with the FIFO kept full: one burst then hold.
    start_frame(128, 1, 0, 0, 4000, 99, 1'b1);
    wait_drain();
    repeat (200) @(negedge mem_clk);

    // Buffer wraps to 0; vsync 3 cycles into the first burst leaves that frame incomplete.
    start_frame(256, 2, 0, 0, 512, 1, 1'b0);
    wait_req();
    repeat (2) @(negedge mem_clk);
    start_frame(256, 2, 0, 5, 512, 99, 1'b1);
    wait_req();
    cfg_width  = 12'd64;
    cfg_base_x = 11'd7;
    cfg_height = 12'd1;
    wait_drain();

    // Reset while a burst request is outstanding.
    start_frame(128, 1, 0, 0, 128, 1, 1'b0);
    wait_req();
    @(posedge mem_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(wr_bus.wr_burst_req), 64'd0);
    check("midrst_len", 64'(wr_bus.wr_burst_len), 64'd0);
    check("midrst_addr", 64'(wr_bus.wr_burst_addr), 64'd0);
    check("midrst_wr_buf_idx", 64'(wr_buf_idx), 64'd0);
    repeat (3) @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (300) @(negedge mem_clk);

    check("bursts_outstanding", 64'(exp_burst_q.size()), 64'd0);
    check("frame_done_outstanding", 64'(exp_done_q.size()), 64'd0);
    check("aclr_outstanding", 64'(exp_aclr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
